// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel-enable divider, h/v counters, sync/bright decode,
// a vertical-region FSM, and a per-frame tick with a wrapping frame counter.
//
// state | meaning
// V_ACT | visible lines, vCount 0..V_VISIBLE-1
// V_FP  | vertical front porch
// V_SY  | vertical sync, vSync driven low
// V_BP  | vertical back porch, ends when vCount wraps to 0
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        reset,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        hSync,
  output logic        vSync,
  output logic        pix_en,
  output logic        frame_tick,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START  = H_VISIBLE + H_FRONT;
  localparam int HS_END    = HS_START + H_SYNC;
  localparam int VFP_START = V_VISIBLE;
  localparam int VSY_START = V_VISIBLE + V_FRONT;
  localparam int VBP_START = VSY_START + V_SYNC;

  localparam logic [3:0]  DIV_LAST   = 4'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS_LAST = 10'(H_VISIBLE - 1);
  localparam logic [9:0]  V_VIS_LAST = 10'(V_VISIBLE - 1);
  // 11-bit bounds so a region end equal to 1024 still compares correctly
  localparam logic [10:0] H_VIS_W    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_W    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START_W = 11'(HS_START);
  localparam logic [10:0] HS_END_W   = 11'(HS_END);
  localparam logic [10:0] VFP_W      = 11'(VFP_START);
  localparam logic [10:0] VSY_W      = 11'(VSY_START);
  localparam logic [10:0] VBP_W      = 11'(VBP_START);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must each be <= 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be within 1..16");
  end

  typedef enum logic [1:0] {V_ACT, V_FP, V_SY, V_BP} v_state_e;

  logic [3:0]  div_q, div_d;
  logic [9:0]  h_count_q, h_count_d;
  logic [9:0]  v_count_q, v_count_d;
  logic [15:0] frame_count_q, frame_count_d;
  v_state_e    v_state_q, v_state_d;

  logic pix_en_w;
  logic line_end;
  logic tick_w;
  logic v_sync_w;
  logic h_sync_w;
  logic bright_w;

  always_comb begin
    pix_en_w  = (div_q == DIV_LAST);
    line_end  = pix_en_w && (h_count_q == H_LAST);
    tick_w    = pix_en_w && (h_count_q == H_VIS_LAST) && (v_count_q == V_VIS_LAST);

    div_d = pix_en_w ? 4'd0 : div_q + 4'd1;

    h_count_d = h_count_q;
    if (pix_en_w) begin
      h_count_d = (h_count_q == H_LAST) ? 10'd0 : h_count_q + 10'd1;
    end

    v_count_d = v_count_q;
    if (line_end) begin
      v_count_d = (v_count_q == V_LAST) ? 10'd0 : v_count_q + 10'd1;
    end

    frame_count_d = frame_count_q + {15'd0, tick_w};
  end

  // FSM next state: look at the new line number so the state flips on the same edge
  always_comb begin
    v_state_d = v_state_q;
    if (line_end) begin
      unique case (v_state_q)
        V_ACT:   if ({1'b0, v_count_d} == VFP_W) v_state_d = V_FP;
        V_FP:    if ({1'b0, v_count_d} == VSY_W) v_state_d = V_SY;
        V_SY:    if ({1'b0, v_count_d} == VBP_W) v_state_d = V_BP;
        V_BP:    if (v_count_d == 10'd0)         v_state_d = V_ACT;
        default: v_state_d = V_ACT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= 4'd0;
      h_count_q     <= 10'd0;
      v_count_q     <= 10'd0;
      frame_count_q <= 16'd0;
      v_state_q     <= V_ACT;
    end else begin
      div_q         <= div_d;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      frame_count_q <= frame_count_d;
      v_state_q     <= v_state_d;
    end
  end

  always_comb begin
    v_sync_w = 1'b1;
    if (v_state_q == V_SY) v_sync_w = 1'b0;
  end

  always_comb begin
    h_sync_w = !(({1'b0, h_count_q} >= HS_START_W) && ({1'b0, h_count_q} < HS_END_W));
    bright_w = ({1'b0, h_count_q} < H_VIS_W) && ({1'b0, v_count_q} < V_VIS_W);
  end

  assign hCount      = h_count_q;
  assign vCount      = v_count_q;
  assign bright      = bright_w;
  assign hSync       = h_sync_w;
  assign vSync       = v_sync_w;
  assign pix_en      = pix_en_w;
  assign frame_tick  = tick_w;
  assign frame_count = frame_count_q;

  function automatic v_state_e region_of(logic [9:0] v);
    if ({1'b0, v} < VFP_W) return V_ACT;
    if ({1'b0, v} < VSY_W) return V_FP;
    if ({1'b0, v} < VBP_W) return V_SY;
    return V_BP;
  endfunction

  a_state_matches_line: assert property (@(posedge clk) disable iff (reset)
    v_state_q == region_of(v_count_q));

  a_tick_in_active: assert property (@(posedge clk) disable iff (reset)
    tick_w |-> (v_state_q == V_ACT));

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a reduced video mode: closed-form raster model checked
// every cycle, directed literal checks, forced frame counter wrap and random resets.
module tb_vga_timing_gen;
  localparam int CD = 3;
  localparam int HV = 20, HF = 3, HS = 5, HB = 4;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  hCount, vCount;
  logic        bright, hSync, vSync, pix_en, frame_tick;
  logic [15:0] frame_count;

  vga_timing_gen #(
    .CLK_DIV(CD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .hCount(hCount), .vCount(vCount), .bright(bright),
    .hSync(hSync), .vSync(vSync), .pix_en(pix_en), .frame_tick(frame_tick),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint mt = 0;
  int     mfc = 0;
  bit     valid = 1'b0;
  bit     rst_s;

  // Closed-form raster position from clocks elapsed since reset release
  function automatic int e_h(longint t);  return int'((t / CD) % HT); endfunction
  function automatic int e_v(longint t);  return int'(((t / CD) / HT) % VT); endfunction
  function automatic bit e_pe(longint t); return (t % CD) == CD - 1; endfunction
  function automatic bit e_tick(longint t);
    return e_pe(t) && e_h(t) == HV - 1 && e_v(t) == VV - 1;
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic compare_model();
    int h, v;
    bit b, hs, vs, pe, tk;
    h  = e_h(mt);
    v  = e_v(mt);
    pe = e_pe(mt);
    tk = e_tick(mt);
    b  = (h < HV) && (v < VV);
    hs = !(h >= HV + HF && h < HV + HF + HS);
    vs = !(v >= VV + VF && v < VV + VF + VS);
    checks++;
    if (hCount != 10'(h) || vCount != 10'(v) || bright != b || hSync != hs ||
        vSync != vs || pix_en != pe || frame_tick != tk || frame_count != 16'(mfc)) begin
      errors++;
      $display("FAIL outputs t=%0d actual h=%0d v=%0d b=%0d hs=%0d vs=%0d pe=%0d tk=%0d fc=%0d required h=%0d v=%0d b=%0d hs=%0d vs=%0d pe=%0d tk=%0d fc=%0d",
               mt, hCount, vCount, bright, hSync, vSync, pix_en, frame_tick, frame_count,
               h, v, b, hs, vs, pe, tk, mfc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    rst_s = reset;
    @(negedge clk);
    if (rst_s) begin
      mt = 0;
      mfc = 0;
      valid = 1'b1;
    end else begin
      if (e_tick(mt)) mfc = (mfc + 1) % 65536;
      mt++;
    end
    if (valid) compare_model();
  endtask

  int h_lit[6]  = '{0, 0, 0, 1, 1, 1};
  int pe_lit[6] = '{0, 0, 1, 0, 0, 1};
  int ticks[$];
  int hs_low, vs_low, k;
  bit found;

  initial begin
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Directed run from release: literal pins for the model
    hs_low = 0;
    vs_low = 0;
    for (int i = 0; i <= 6000; i++) begin
      if (i < 6) begin
        check("start_hcount", hCount, h_lit[i]);
        check("start_pix_en", pix_en, pe_lit[i]);
      end
      if (i == 0) begin
        check("rst_bright", bright, 1);
        check("rst_hsync", hSync, 1);
        check("rst_vsync", vSync, 1);
        check("rst_vcount", vCount, 0);
        check("rst_frame_tick", frame_tick, 0);
        check("rst_frame_count", frame_count, 0);
      end
      if (i == 59) check("bright_last_visible", bright, 1);
      if (i == 60) check("bright_drop", bright, 0);
      if (i == 95) begin
        check("line_end_h", hCount, 31);
        check("line_end_v", vCount, 0);
      end
      if (i == 96) begin
        check("line_wrap_h", hCount, 0);
        check("line_wrap_v", vCount, 1);
      end
      if (i < 96 && !hSync) hs_low++;
      if (ticks.size() == 1 && !vSync) vs_low++;
      if (frame_tick) ticks.push_back(i);
      if (i < 6000) step();
    end
    check("hsync_low_clks", hs_low, 15);
    check("vsync_low_clks", vs_low, 192);
    check("tick_count", ticks.size(), 3);
    if (ticks.size() >= 2) begin
      check("first_tick_time", ticks[0], 1115);
      check("frame_period", ticks[1] - ticks[0], 1824);
    end else begin
      check("tick_times_present", ticks.size(), 2);
    end
    check("frame_count_after_3", frame_count, 3);

    // Mid-frame reset at (h=10, v=8)
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      if (hCount == 10'd10 && vCount == 10'd8) found = 1'b1;
      else step();
    end
    check("reach_mid_frame", found, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_h", hCount, 0);
    check("midrst_v", vCount, 0);
    check("midrst_fc", frame_count, 0);
    k = 0;
    while (!frame_tick && k < 3000) begin
      step();
      k++;
    end
    check("tick_after_midrst", k, 1115);

    // Frame counter wrap from a forced 65535
    step();
    force dut.frame_count_q = 16'hFFFF;
    mfc = 65535;
    step();
    release dut.frame_count_q;
    k = 0;
    while (!frame_tick && k < 3000) begin
      step();
      k++;
    end
    check("wrap_tick_seen", frame_tick, 1);
    check("fc_before_wrap", frame_count, 65535);
    step();
    check("fc_wrapped", frame_count, 0);
    check("wrap_h", hCount, HV);
    check("wrap_v", vCount, VV - 1);

    // Random run lengths with random reset pulses
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(50, 2500)) step();
      reset = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      reset = 1'b0;
    end
    repeat (2000) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
